stump_mem_arbiter: RTL and testbench

- Shares the single Stump memory port between the processor and a debug/host port.
- The processor side issues one access at a time, from instruction fetch or load/store; the host side is used for memory inspect/patch.
- Sequences each access through a fixed-latency memory timing: strobe, wait states, capture, then a one-cycle acknowledge.
- Two-way round-robin arbitration, plus a halt mode that gives the host exclusive access.

---
 rtl/stump_mem_pkg.sv | 19 +
 rtl/stump_mem_arbiter_if.sv | 20 ++
 rtl/stump_rr_pick.sv | 28 ++
 rtl/stump_mem_arbiter.sv | 104 ++++++++++
 tb/tb_stump_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stump_mem_pkg.sv
// Shared types and defaults for the Stump memory-port arbiter.
package stump_mem_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int CNT_W      = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      CPU = 1'b0,
      DBG = 1'b1
   } owner_e;

endpackage

// File: rtl/stump_mem_arbiter_if.sv
// One requester port of the arbiter: level request held until a one-cycle ack.
interface stump_mem_arbiter_if #(
   parameter int ADDR_W = stump_mem_pkg::ADDR_W_DEF,
   parameter int DATA_W = stump_mem_pkg::DATA_W_DEF
) ();

   logic              req;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, output wen, output addr, output wdata,
                   input rdata, input ack);

   modport slave  (input req, input wen, input addr, input wdata,
                   output rdata, output ack);

endinterface

// File: rtl/stump_rr_pick.sv
// Two-way round-robin picker; halt masks the processor request.
module stump_rr_pick
   import stump_mem_pkg::*;
(
   input  logic   cpu_req,
   input  logic   dbg_req,
   input  logic   dbg_halt,
   input  owner_e last_grant,
   output logic   grant_valid,
   output owner_e grant_owner
);

   logic cpu_ok;

   assign cpu_ok = cpu_req & ~dbg_halt;

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      grant_valid = cpu_ok | dbg_req;
      grant_owner = DBG;
      if (cpu_ok && dbg_req) begin
         grant_owner = (last_grant == CPU) ? DBG : CPU;
      end else if (cpu_ok) begin
         grant_owner = CPU;
      end
   end

endmodule

// File: rtl/stump_mem_arbiter.sv
// Shares the single Stump memory port between the processor and the host port,
// sequencing each access as strobe, wait states, capture and a one-cycle ack.
module stump_mem_arbiter
   import stump_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   stump_mem_arbiter_if.slave cpu,
   stump_mem_arbiter_if.slave dbg,
   output logic              cpu_stall,
   input  logic              dbg_halt,
   output logic              halted,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ren,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e             state_q, state_d;
   owner_e             owner_q, last_grant_q;
   logic               wen_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               grant_valid;
   owner_e             grant_owner;

   stump_rr_pick u_pick (
      .cpu_req     (cpu.req),
      .dbg_req     (dbg.req),
      .dbg_halt    (dbg_halt),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // NOTE: all sequential state uses non-blocking assignments.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = ACCESS;
         ACCESS:  if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latches, wait counter, capture registers and fairness memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q      <= CPU;
         last_grant_q <= DBG;
         wen_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         cpu.rdata    <= '0;
         dbg.rdata    <= '0;
      end else begin
         case (state_q)
            IDLE: if (grant_valid) begin
               owner_q <= grant_owner;
               wen_q   <= (grant_owner == CPU) ? cpu.wen   : dbg.wen;
               addr_q  <= (grant_owner == CPU) ? cpu.addr  : dbg.addr;
               wdata_q <= (grant_owner == CPU) ? cpu.wdata : dbg.wdata;
               cnt_q   <= CNT_W'(WAIT_STATES);
            end
            ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 3'd1;
               end else if (owner_q == CPU) begin
                  cpu.rdata <= wen_q ? '0 : mem_rdata;
               end else begin
                  dbg.rdata <= wen_q ? '0 : mem_rdata;
               end
            end
            RESP:    last_grant_q <= owner_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_ren   = (state_q == ACCESS) && !wen_q;
      mem_wen   = (state_q == ACCESS) && wen_q;
      cpu.ack   = (state_q == RESP) && (owner_q == CPU);
      dbg.ack   = (state_q == RESP) && (owner_q == DBG);
      cpu_stall = cpu.req && !cpu.ack;
      halted    = dbg_halt && !((state_q != IDLE) && (owner_q == CPU));
   end

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Directed bench for stump_mem_arbiter: cycle-exact strobe/ack checks plus an
// ack scoreboard; a second instance covers the zero-wait-state build.
module tb_stump_mem_arbiter;
   import stump_mem_pkg::*;

   typedef struct packed {
      owner_e      owner;
      logic [15:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic dbg_halt;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   stump_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
   stump_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dbg_if ();
   stump_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu0_if ();
   stump_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) dbg0_if ();

   logic        cpu_stall, halted, mem_ren, mem_wen;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall0, halted0, mem_ren0, mem_wen0;
   logic [15:0] mem_addr0, mem_wdata0;

   stump_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) u_dut (
      .clk (clk), .rst (rst), .cpu (cpu_if), .dbg (dbg_if),
      .cpu_stall (cpu_stall), .dbg_halt (dbg_halt), .halted (halted),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_ren (mem_ren),
      .mem_wen (mem_wen), .mem_rdata (mem_rdata)
   );

   stump_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) u_dut0 (
      .clk (clk), .rst (rst), .cpu (cpu0_if), .dbg (dbg0_if),
      .cpu_stall (cpu_stall0), .dbg_halt (1'b0), .halted (halted0),
      .mem_addr (mem_addr0), .mem_wdata (mem_wdata0), .mem_ren (mem_ren0),
      .mem_wen (mem_wen0), .mem_rdata (16'h5A5A)
   );

   // Memory model: each word defaults to 0xA000|index, with 0xBEEF at 0x10.
   logic [15:0] mem_model [256];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) mem_model[i] <= 16'hA000 | 16'(i);
         mem_model[8'h10] <= 16'hBEEF;
      end else if (mem_wen) begin
         mem_model[mem_addr[7:0]] <= mem_wdata;
      end
   end

   assign mem_rdata = mem_model[mem_addr[7:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk_exp(input owner_e owner, input logic [15:0] d);
      exp_t e;
      e.owner = owner;
      e.rdata = d;
      return e;
   endfunction

   // Every ack of the main instance is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst && (cpu_if.ack || dbg_if.ack)) begin
         check("sb_one_ack", {31'd0, cpu_if.ack & dbg_if.ack}, 32'd0);
         if (sb.size() == 0) begin
            check("sb_unexpected_ack", sb.size(), 32'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_owner", {31'd0, dbg_if.ack}, {31'd0, e.owner == DBG});
            check("sb_rdata", dbg_if.ack ? dbg_if.rdata : cpu_if.rdata, e.rdata);
         end
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_issue(input logic wen, input logic [15:0] addr, input logic [15:0] wdata);
      cpu_if.wen = wen; cpu_if.addr = addr; cpu_if.wdata = wdata; cpu_if.req = 1'b1;
   endtask

   task automatic dbg_issue(input logic wen, input logic [15:0] addr, input logic [15:0] wdata);
      dbg_if.wen = wen; dbg_if.addr = addr; dbg_if.wdata = wdata; dbg_if.req = 1'b1;
   endtask

   // Counts negedges until the chosen ack appears, bounded by a cycle budget.
   task automatic wait_ack(input logic want_dbg, input int exp_n, input string tag);
      int   n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         seen = want_dbg ? dbg_if.ack : cpu_if.ack;
      end
      check(tag, n, exp_n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      dbg_halt = 1'b0;
      cpu_if.req = 1'b0;  cpu_if.wen = 1'b0;  cpu_if.addr = '0;  cpu_if.wdata = '0;
      dbg_if.req = 1'b0;  dbg_if.wen = 1'b0;  dbg_if.addr = '0;  dbg_if.wdata = '0;
      cpu0_if.req = 1'b0; cpu0_if.wen = 1'b0; cpu0_if.addr = '0; cpu0_if.wdata = '0;
      dbg0_if.req = 1'b0; dbg0_if.wen = 1'b0; dbg0_if.addr = '0; dbg0_if.wdata = '0;

      // Reset state
      @(negedge clk);
      check("rst_mem_ren", mem_ren, 0);
      check("rst_mem_wen", mem_wen, 0);
      check("rst_cpu_ack", cpu_if.ack, 0);
      check("rst_dbg_ack", dbg_if.ack, 0);
      check("rst_cpu_rdata", cpu_if.rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_halted", halted, 0);
      check("rst_dut0_wen", mem_wen0, 0);
      next_cycle(); rst = 1'b1;
      next_cycle();

      // CPU read alone
      cpu_issue(1'b0, 16'h0010, 16'h0000);
      sb.push_back(mk_exp(CPU, 16'hBEEF));
      @(negedge clk);
      check("t1_c0_stall", cpu_stall, 1);
      check("t1_c0_ren", mem_ren, 0);
      @(negedge clk);
      check("t1_c1_ren", mem_ren, 1);
      check("t1_c1_wen", mem_wen, 0);
      check("t1_c1_addr", mem_addr, 16'h0010);
      @(negedge clk);
      check("t1_c2_ren", mem_ren, 1);
      check("t1_c2_stall", cpu_stall, 1);
      @(negedge clk);
      check("t1_c3_ack", cpu_if.ack, 1);
      check("t1_c3_rdata", cpu_if.rdata, 16'hBEEF);
      check("t1_c3_stall", cpu_stall, 0);
      check("t1_c3_ren", mem_ren, 0);
      next_cycle(); cpu_if.req = 1'b0;
      @(negedge clk);
      check("t1_c4_ack", cpu_if.ack, 0);
      check("t1_c4_rdata_hold", cpu_if.rdata, 16'hBEEF);

      // Simultaneous requests straight after reset: CPU wins the first tie
      next_cycle(); rst = 1'b0;
      #1;
      check("t2_rst_rdata", cpu_if.rdata, 0);
      next_cycle(); rst = 1'b1;
      next_cycle();
      cpu_issue(1'b1, 16'h0020, 16'h1234);
      dbg_issue(1'b0, 16'h0030, 16'h0000);
      sb.push_back(mk_exp(CPU, 16'h0000));
      sb.push_back(mk_exp(DBG, 16'hA030));
      @(negedge clk);
      @(negedge clk);
      check("t2_c1_wen", mem_wen, 1);
      check("t2_c1_ren", mem_ren, 0);
      check("t2_c1_addr", mem_addr, 16'h0020);
      check("t2_c1_wdata", mem_wdata, 16'h1234);
      @(negedge clk);
      check("t2_c2_wen", mem_wen, 1);
      @(negedge clk);
      check("t2_c3_cpu_ack", cpu_if.ack, 1);
      check("t2_c3_dbg_ack", dbg_if.ack, 0);
      next_cycle(); cpu_if.req = 1'b0;
      @(negedge clk);
      check("t2_c4_ren", mem_ren, 0);
      @(negedge clk);
      check("t2_c5_ren", mem_ren, 1);
      check("t2_c5_addr", mem_addr, 16'h0030);
      @(negedge clk);
      check("t2_c6_ren", mem_ren, 1);
      @(negedge clk);
      check("t2_c7_dbg_ack", dbg_if.ack, 1);
      next_cycle(); dbg_if.req = 1'b0;

      // Fairness with both requests held high
      next_cycle();
      cpu_issue(1'b0, 16'h0020, 16'h0000);
      dbg_issue(1'b0, 16'h0010, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         sb.push_back(mk_exp((k % 2 == 0) ? CPU : DBG, (k % 2 == 0) ? 16'h1234 : 16'hBEEF));
      end
      for (int k = 0; k < 4; k++) begin
         wait_ack(logic'(k % 2), 4, "t3_ack_interval");
         check("t3_cpu_turn", cpu_if.ack, (k % 2 == 0) ? 1 : 0);
      end
      next_cycle(); cpu_if.req = 1'b0; dbg_if.req = 1'b0;

      // Halt during a CPU access
      next_cycle();
      cpu_issue(1'b0, 16'h0010, 16'h0000);
      sb.push_back(mk_exp(CPU, 16'hBEEF));
      @(negedge clk);
      next_cycle(); dbg_halt = 1'b1;
      @(negedge clk);
      check("t4_c1_halted", halted, 0);
      check("t4_c1_ren", mem_ren, 1);
      @(negedge clk);
      @(negedge clk);
      check("t4_c3_ack", cpu_if.ack, 1);
      check("t4_c3_halted", halted, 0);
      next_cycle(); cpu_if.req = 1'b0;
      @(negedge clk);
      check("t4_c4_halted", halted, 1);
      next_cycle();
      cpu_issue(1'b0, 16'h0020, 16'h0000);
      dbg_issue(1'b1, 16'h0040, 16'h5555);
      sb.push_back(mk_exp(DBG, 16'h0000));
      @(negedge clk);
      @(negedge clk);
      check("t4_c6_wen", mem_wen, 1);
      check("t4_c6_addr", mem_addr, 16'h0040);
      @(negedge clk);
      @(negedge clk);
      check("t4_c8_dbg_ack", dbg_if.ack, 1);
      check("t4_c8_cpu_ack", cpu_if.ack, 0);
      check("t4_c8_stall", cpu_stall, 1);
      next_cycle(); dbg_if.req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t4_c10_ren", mem_ren, 0);
      check("t4_c10_stall", cpu_stall, 1);
      check("t4_c10_halted", halted, 1);
      next_cycle(); dbg_halt = 1'b0;
      sb.push_back(mk_exp(CPU, 16'h1234));
      wait_ack(1'b0, 4, "t4_resume_latency");
      check("t4_resume_halted", halted, 0);
      next_cycle(); cpu_if.req = 1'b0;

      // Reset in the middle of a CPU read
      next_cycle();
      cpu_issue(1'b0, 16'h0010, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      check("t5_c1_ren", mem_ren, 1);
      next_cycle(); rst = 1'b0;
      #1;
      check("t5_rst_ren", mem_ren, 0);
      check("t5_rst_ack", cpu_if.ack, 0);
      next_cycle(); rst = 1'b1;
      sb.push_back(mk_exp(CPU, 16'hBEEF));
      @(negedge clk);
      check("t5_idle_ren", mem_ren, 0);
      wait_ack(1'b0, 3, "t5_reissue_latency");
      next_cycle(); cpu_if.req = 1'b0;

      // Zero-wait-state instance: host write
      next_cycle();
      dbg0_if.wen = 1'b1; dbg0_if.addr = 16'h0050; dbg0_if.wdata = 16'hCAFE; dbg0_if.req = 1'b1;
      @(negedge clk);
      check("t6_c0_wen", mem_wen0, 0);
      @(negedge clk);
      check("t6_c1_wen", mem_wen0, 1);
      check("t6_c1_ren", mem_ren0, 0);
      check("t6_c1_addr", mem_addr0, 16'h0050);
      check("t6_c1_wdata", mem_wdata0, 16'hCAFE);
      check("t6_c1_ack", dbg0_if.ack, 0);
      @(negedge clk);
      check("t6_c2_wen", mem_wen0, 0);
      check("t6_c2_ack", dbg0_if.ack, 1);
      check("t6_c2_rdata", dbg0_if.rdata, 0);
      check("t6_c2_cpu_ack", cpu0_if.ack, 0);
      next_cycle(); dbg0_if.req = 1'b0;
      @(negedge clk);
      check("t6_c3_ack", dbg0_if.ack, 0);
      check("t6_halted", halted0, 0);
      check("t6_stall", cpu_stall0, 0);

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
